// File: rtl/reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reset_sequencer_pkg : shared state encoding and width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } seq_state_e;

    // $clog2 that never returns 0, so single-value fields still get one bit
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_timer.sv
// ---------------------------------------------------------------------------
// rst_seq_timer : clearable saturating up-counter with terminal-count flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rst_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] tc_value,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == tc_value);

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer : releases downstream reset domains in order with ack/timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                por_rst_in,
    input  logic [NUM_STAGES-1:0]               stage_ack,
    output logic [NUM_STAGES-1:0]               stage_rst_out,
    output logic                                all_done,
    output logic                                timeout_err,
    output logic [clog2_min1(NUM_STAGES)-1:0]   fault_stage
);

    localparam int c_fs_w  = clog2_min1(NUM_STAGES);
    localparam int c_cnt_w = clog2_min1(((HOLD_CYCLES > TIMEOUT_CYCLES) ?
                                         HOLD_CYCLES : TIMEOUT_CYCLES) + 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last   = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_fs_w-1:0]  c_last_stage = c_fs_w'(NUM_STAGES - 1);
    localparam bit                 c_tmo_en     = (TIMEOUT_CYCLES != 0);

    seq_state_e              state_q, state_d;
    logic [c_fs_w-1:0]       stage_idx_q, stage_idx_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic                    all_done_q, all_done_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [c_fs_w-1:0]       fault_stage_q, fault_stage_d;

    logic                    tmr_clear;
    logic                    tmr_inc;
    logic [c_cnt_w-1:0]      tmr_tc_value;
    logic                    tmr_tc;

    // One timer serves both phases; only its terminal value changes
    rst_seq_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .inc      (tmr_inc),
        .tc_value (tmr_tc_value),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        stage_idx_d   = stage_idx_q;
        stage_rst_d   = stage_rst_q;
        all_done_d    = all_done_q;
        timeout_err_d = timeout_err_q;
        fault_stage_d = fault_stage_q;
        tmr_clear     = 1'b0;
        tmr_inc       = 1'b0;
        tmr_tc_value  = (state_q == ST_HOLD) ? c_hold_last : c_tmo_last;

        if (por_rst_in) begin
            state_d       = ST_IDLE;
            stage_idx_d   = '0;
            stage_rst_d   = '1;
            all_done_d    = 1'b0;
            timeout_err_d = 1'b0;
            fault_stage_d = '0;
            tmr_clear     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stage_rst_d = '1;
                    all_done_d  = 1'b0;
                    tmr_clear   = 1'b1;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (tmr_tc) begin
                        stage_rst_d[stage_idx_q] = 1'b0;
                        tmr_clear                = 1'b1;
                        state_d                  = ST_WAIT_ACK;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack on the last timeout cycle is checked first and wins
                    if (stage_ack[stage_idx_q]) begin
                        tmr_clear = 1'b1;
                        if (stage_idx_q == c_last_stage) begin
                            all_done_d = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            stage_idx_d = stage_idx_q + 1'b1;
                            state_d     = ST_HOLD;
                        end
                    end else if (c_tmo_en && tmr_tc) begin
                        stage_rst_d   = '1;
                        all_done_d    = 1'b0;
                        timeout_err_d = 1'b1;
                        fault_stage_d = stage_idx_q;
                        state_d       = ST_FAULT;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_DONE:  ;
                ST_FAULT: ;
                default: begin
                    state_d     = ST_IDLE;
                    stage_rst_d = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            stage_idx_q   <= '0;
            stage_rst_q   <= '1;
            all_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            stage_idx_q   <= stage_idx_d;
            stage_rst_q   <= stage_rst_d;
            all_done_q    <= all_done_d;
            timeout_err_q <= timeout_err_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign stage_rst_out = stage_rst_q;
    assign all_done      = all_done_q;
    assign timeout_err   = timeout_err_q;
    assign fault_stage   = fault_stage_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer : scenario bench with an event-time reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reset_sequencer;

    localparam int NS    = 4;
    localparam int HOLD  = 16;
    localparam int TMO   = 64;
    localparam int NEVER = 1000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          por_rst_in;
    logic [NS-1:0] stage_ack;
    logic [NS-1:0] stage_rst_out;
    logic          all_done;
    logic          timeout_err;
    logic [1:0]    fault_stage;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    reset_sequencer #(
        .NUM_STAGES     (NS),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .por_rst_in    (por_rst_in),
        .stage_ack     (stage_ack),
        .stage_rst_out (stage_rst_out),
        .all_done      (all_done),
        .timeout_err   (timeout_err),
        .fault_stage   (fault_stage)
    );

    // Releases por/reset at the current negedge and follows one sequence.
    // Stage k releases HOLD edges after its start edge; its ack is seen dly[k]
    // WAIT cycles later, or the stage times out TMO edges after release.
    task automatic run_seq(input int d0, input int d1, input int d2, input int d3,
                           input bit tie_high, input int stop_after, input int tail,
                           input string name);
        int dly[NS]; int rel[NS]; int acc[NS]; int drv[NS];
        int s, t, fault_edge, fault_k, done_edge, end_edge, n;
        bit fault;
        logic [NS-1:0] exp_rst;
        logic exp_done, exp_err;
        logic [1:0] exp_fs;
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        reset = 1'b0;
        por_rst_in = 1'b0;
        stage_ack = tie_high ? 4'hF : 4'h0;
        s = edge_cnt + 1;
        t = s; fault = 1'b0; fault_edge = NEVER; fault_k = 0; done_edge = NEVER;
        for (int k = 0; k < NS; k++) begin
            rel[k] = NEVER; acc[k] = NEVER; drv[k] = NEVER;
        end
        for (int k = 0; k < NS; k++) begin
            if (!fault) begin
                rel[k] = t + HOLD;
                if (dly[k] < NEVER) drv[k] = rel[k] + 1 + dly[k];
                if (dly[k] >= TMO) begin
                    fault = 1'b1; fault_k = k; fault_edge = rel[k] + TMO;
                end else begin
                    acc[k] = drv[k]; t = acc[k];
                end
            end
        end
        if (!fault) done_edge = t;
        end_edge = (stop_after > 0) ? s + stop_after
                                    : (fault ? fault_edge : done_edge) + tail;
        while (edge_cnt < end_edge) begin
            @(negedge clk);
            n = edge_cnt;
            for (int k = 0; k < NS; k++) exp_rst[k] = (n < rel[k]);
            if (fault && n >= fault_edge) exp_rst = 4'hF;
            exp_done = (n >= done_edge);
            exp_err  = fault && (n >= fault_edge);
            exp_fs   = exp_err ? 2'(fault_k) : 2'd0;
            checks++;
            if (stage_rst_out !== exp_rst) begin
                errors++;
                $display("FAIL %s stage_rst_out at edge +%0d: got %b expected %b",
                         name, n - s + 1, stage_rst_out, exp_rst);
            end
            checks++;
            if (all_done !== exp_done) begin
                errors++;
                $display("FAIL %s all_done at edge +%0d: got %b expected %b",
                         name, n - s + 1, all_done, exp_done);
            end
            checks++;
            if (timeout_err !== exp_err) begin
                errors++;
                $display("FAIL %s timeout_err at edge +%0d: got %b expected %b",
                         name, n - s + 1, timeout_err, exp_err);
            end
            checks++;
            if (fault_stage !== exp_fs) begin
                errors++;
                $display("FAIL %s fault_stage at edge +%0d: got %0d expected %0d",
                         name, n - s + 1, fault_stage, exp_fs);
            end
            if (!tie_high) begin
                for (int j = 0; j < NS; j++) begin
                    if (n + 1 == drv[j])     stage_ack[j] = 1'b1;
                    else if (n + 1 > acc[j]) stage_ack[j] = 1'($urandom_range(0, 1));
                    else                     stage_ack[j] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; por_rst_in = 1'b0; stage_ack = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (stage_rst_out !== 4'hF) begin errors++; $display("FAIL reset stage_rst_out: got %b expected 1111", stage_rst_out); end
        checks++;
        if (all_done !== 1'b0) begin errors++; $display("FAIL reset all_done: got %b expected 0", all_done); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset timeout_err: got %b expected 0", timeout_err); end
        checks++;
        if (fault_stage !== 2'd0) begin errors++; $display("FAIL reset fault_stage: got %0d expected 0", fault_stage); end
    endtask

    task automatic test_normal();
        run_seq(3, 3, 3, 3, 1'b0, 0, 5, "normal");
    endtask

    task automatic test_sync_reset(input string name);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (stage_rst_out !== 4'hF) begin errors++; $display("FAIL %s stage_rst_out: got %b expected 1111", name, stage_rst_out); end
        checks++;
        if (all_done !== 1'b0) begin errors++; $display("FAIL %s all_done: got %b expected 0", name, all_done); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL %s timeout_err: got %b expected 0", name, timeout_err); end
        checks++;
        if (fault_stage !== 2'd0) begin errors++; $display("FAIL %s fault_stage: got %0d expected 0", name, fault_stage); end
    endtask

    task automatic test_all_high();
        run_seq(0, 0, 0, 0, 1'b1, 0, 5, "all_high");
    endtask

    task automatic test_por_mid();
        por_rst_in = 1'b1;
        @(negedge clk);
        run_seq(0, NEVER, 0, 0, 1'b0, 38, 0, "por_mid_pre");
        por_rst_in = 1'b1;
        @(negedge clk);
        checks++;
        if (stage_rst_out !== 4'hF) begin errors++; $display("FAIL por_mid stage_rst_out: got %b expected 1111", stage_rst_out); end
        checks++;
        if (all_done !== 1'b0) begin errors++; $display("FAIL por_mid all_done: got %b expected 0", all_done); end
        run_seq(2, 2, 2, 2, 1'b0, 0, 5, "por_mid_restart");
    endtask

    task automatic test_timeout();
        por_rst_in = 1'b1;
        @(negedge clk);
        run_seq(1, 4, TMO, 0, 1'b0, 0, 200, "timeout");
    endtask

    task automatic test_fault_stage3();
        run_seq(0, 0, 0, NEVER, 1'b0, 0, 10, "fault_stage3");
    endtask

    task automatic test_por_in_fault();
        por_rst_in = 1'b1;
        @(negedge clk);
        checks++;
        if (stage_rst_out !== 4'hF) begin errors++; $display("FAIL por_fault stage_rst_out: got %b expected 1111", stage_rst_out); end
        checks++;
        if (all_done !== 1'b0) begin errors++; $display("FAIL por_fault all_done: got %b expected 0", all_done); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL por_fault timeout_err: got %b expected 0", timeout_err); end
        checks++;
        if (fault_stage !== 2'd0) begin errors++; $display("FAIL por_fault fault_stage: got %0d expected 0", fault_stage); end
    endtask

    task automatic test_ack_on_timeout();
        run_seq(0, TMO - 1, 0, 5, 1'b0, 0, 5, "ack_on_timeout");
    endtask

    task automatic test_random();
        int d[NS];
        for (int it = 0; it < 6; it++) begin
            por_rst_in = 1'b1;
            @(negedge clk);
            for (int k = 0; k < NS; k++) d[k] = $urandom_range(0, 12);
            if ($urandom_range(0, 2) == 0) d[$urandom_range(0, NS - 1)] = $urandom_range(TMO - 2, TMO + 1);
            run_seq(d[0], d[1], d[2], d[3], 1'b0, 0, 4, "random");
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_sync_reset("sync_reset_done");
        test_all_high();
        test_por_mid();
        test_timeout();
        test_sync_reset("sync_reset_fault");
        test_fault_stage3();
        test_por_in_fault();
        test_ack_on_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
